// File: rtl/mem_ctrl.sv
// Byte-wide RAM arbiter/sequencer for the IF and MEM stages; MEM has priority.
// Optional `MEM_CTRL_IO_THROTTLE_EN`: stall I/O stores while the I/O FIFO is full.
module mem_ctrl #(
  parameter logic [1:0] IO_BASE = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        io_buffer_full,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [2:0]  mem_len,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  output logic        if_stall,
  output logic        mem_stall
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [2:0]  r_rcnt;
  logic [2:0]  r_len;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic        r_owner_mem;
  logic        r_first;
  logic        r_frz;
  logic [7:0]  r_din_save;
  logic [31:0] r_ram_a;
  logic [7:0]  r_ram_dout;
  logic        r_ram_wr;
  logic        r_if_done;
  logic        r_mem_done;
  logic [31:0] r_if_rdata;
  logic [31:0] r_mem_rdata;

  logic [2:0]  w_mem_len;
  logic [7:0]  w_din;
  logic [31:0] w_buf_next;
  logic        w_thr_grant;
  logic        w_thr_wr;

  always_comb begin
    w_mem_len = 3'd4;
    if (mem_len == 3'd1 || mem_len == 3'd2) w_mem_len = mem_len;
  end

  // The RAM keeps returning data while rdy is low, so the byte that was in
  // flight when the freeze began is parked and consumed on the resume edge.
  assign w_din      = r_frz ? r_din_save : ram_din;
  assign w_buf_next = r_buf | ({24'b0, w_din} << {r_rcnt[1:0], 3'b000});

`ifdef MEM_CTRL_IO_THROTTLE_EN
  assign w_thr_grant = (mem_addr[17:16] == IO_BASE) && io_buffer_full;
  assign w_thr_wr    = (r_base[17:16] == IO_BASE) && io_buffer_full;
`else
  logic w_unused_io;
  assign w_unused_io = io_buffer_full;
  assign w_thr_grant = 1'b0;
  assign w_thr_wr    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_rcnt      <= 3'd0;
      r_len       <= 3'd0;
      r_base      <= 32'd0;
      r_wdata     <= 32'd0;
      r_buf       <= 32'd0;
      r_owner_mem <= 1'b0;
      r_first     <= 1'b0;
      r_frz       <= 1'b0;
      r_din_save  <= 8'd0;
      r_ram_a     <= 32'd0;
      r_ram_dout  <= 8'd0;
      r_ram_wr    <= 1'b0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_rdata  <= 32'd0;
      r_mem_rdata <= 32'd0;
    end else begin
      r_frz <= !rdy;
      if (!r_frz) r_din_save <= ram_din;
      if (rdy) begin
        case (r_state)
          S_IDLE: begin
            r_cnt    <= 3'd0;
            r_rcnt   <= 3'd0;
            r_buf    <= 32'd0;
            r_first  <= 1'b1;
            r_ram_wr <= 1'b0;
            if (mem_req) begin
              r_owner_mem <= 1'b1;
              r_base      <= mem_addr;
              r_wdata     <= mem_wdata;
              r_len       <= w_mem_len;
              r_ram_a     <= mem_addr;
              if (mem_we) begin
                r_state <= S_WR;
                if (!w_thr_grant) begin
                  r_ram_dout <= mem_wdata[7:0];
                  r_ram_wr   <= 1'b1;
                  r_cnt      <= 3'd1;
                end
              end else begin
                r_state <= S_RD;
                r_cnt   <= 3'd1;
              end
            end else if (if_req && !flush) begin
              r_owner_mem <= 1'b0;
              r_base      <= if_addr;
              r_len       <= 3'd4;
              r_ram_a     <= if_addr;
              r_state     <= S_RD;
              r_cnt       <= 3'd1;
            end
          end
          S_RD: begin
            if (!r_owner_mem && flush) begin
              r_state <= S_IDLE;
              r_cnt   <= 3'd0;
            end else begin
              r_first <= 1'b0;
              if (r_cnt < r_len) begin
                r_ram_a <= r_base + {29'b0, r_cnt};
                r_cnt   <= r_cnt + 3'd1;
              end
              // No byte is on ram_din yet in the first address cycle.
              if (!r_first) begin
                r_buf  <= w_buf_next;
                r_rcnt <= r_rcnt + 3'd1;
                if (r_rcnt == r_len - 3'd1) begin
                  r_state <= S_DONE;
                  if (r_owner_mem) begin
                    r_mem_rdata <= w_buf_next;
                    r_mem_done  <= 1'b1;
                  end else begin
                    r_if_rdata <= w_buf_next;
                    r_if_done  <= 1'b1;
                  end
                end
              end
            end
          end
          S_WR: begin
            if (r_cnt < r_len) begin
              if (w_thr_wr) begin
                r_ram_wr <= 1'b0;
              end else begin
                r_ram_a    <= r_base + {29'b0, r_cnt};
                r_ram_dout <= r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                r_ram_wr   <= 1'b1;
                r_cnt      <= r_cnt + 3'd1;
              end
            end else begin
              r_ram_wr   <= 1'b0;
              r_state    <= S_DONE;
              r_mem_done <= 1'b1;
            end
          end
          S_DONE: begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            r_state    <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ram_a     = r_ram_a;
  assign ram_dout  = r_ram_dout;
  assign ram_wr    = r_ram_wr & rdy;
  assign if_done   = r_if_done;
  assign mem_done  = r_mem_done;
  assign if_rdata  = r_if_rdata;
  assign mem_rdata = r_mem_rdata;
  assign if_stall  = if_req & ~r_if_done;
  assign mem_stall = mem_req & ~r_mem_done;

endmodule
